gray_conv_pipe: RTL and testbench

//  Streaming, pipelined Gray<->binary converter; direction selectable per beat.

---
 rtl/gray_pkg.sv | 18 +
 rtl/gray_conv_stage.sv | 87 ++++++++
 rtl/gray_conv_pipe.sv | 112 +++++++++++
 tb/tb_gray_conv_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Package: gray_pkg
// Mode encodings and the adjacency helper shared by the Gray/binary converter.
package gray_pkg;

  localparam logic MODE_G2B    = 1'b0;
  localparam logic MODE_B2G    = 1'b1;
  // Widest operand the adjacency helper accepts; callers zero-extend.
  localparam int   GRAY_MAX_DW = 64;

  // True when more than one bit of v is set: clearing the lowest set bit
  // must leave nothing behind for a legal single-step Gray change.
  function automatic logic gray_popcnt_gt1(input logic [GRAY_MAX_DW-1:0] v);
    logic [GRAY_MAX_DW-1:0] w_rest;
    w_rest = v & (v - 64'd1);
    return (w_rest != {GRAY_MAX_DW{1'b0}});
  endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// Module: gray_conv_stage
// One pipeline slot of the Gray/binary converter. In gray->bin mode it
// resolves bits HI..LO of the operand using the binary bit just above the
// chunk (in_carry). The FIRST slot also performs the whole bin->gray
// conversion; later slots pass bin->gray beats through untouched.
// An empty chunk (HI < LO) simply forwards the beat.
module gray_conv_stage
  import gray_pkg::*;
#(
  parameter int DW    = 32,
  parameter int HI    = 31,
  parameter int LO    = 16,
  parameter bit FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [DW-1:0] in_data,
  input  logic          in_carry,
  input  logic          in_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_mode,
  output logic [DW-1:0] out_data,
  output logic          out_carry,
  output logic          out_err
);

  logic          r_valid;
  logic          r_mode;
  logic [DW-1:0] r_data;
  logic          r_carry;
  logic          r_err;

  logic [DW-1:0] w_data;
  logic          w_carry;
  logic          w_run;

  // Slot accepts when empty or when its current beat leaves this cycle.
  assign in_ready = !r_valid || out_ready;

  // Resolve this slot's chunk MSB-first from the incoming carry.
  always_comb begin
    w_data  = in_data;
    w_run   = in_carry;
    w_carry = in_carry;
    if (FIRST && (in_mode == MODE_B2G)) begin
      w_data = in_data ^ (in_data >> 1);
    end else if (in_mode == MODE_G2B) begin
      for (int i = DW - 1; i >= 0; i--) begin
        w_run     = ((i <= HI) && (i >= LO)) ? (w_run ^ in_data[i]) : w_run;
        w_data[i] = ((i <= HI) && (i >= LO)) ? w_run : in_data[i];
      end
      w_carry = w_run;
    end else begin
      w_data = in_data;
    end
  end

  // Capture the beat (or a bubble) whenever the slot may advance; hold otherwise.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_valid <= 1'b0;
      r_mode  <= MODE_G2B;
      r_data  <= {DW{1'b0}};
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_mode  <= in_mode;
        r_data  <= w_data;
        r_carry <= w_carry;
        r_err   <= in_err;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_mode  = r_mode;
  assign out_data  = r_data;
  assign out_carry = r_carry;
  assign out_err   = r_err;

endmodule

// File: rtl/gray_conv_pipe.sv
// Module: gray_conv_pipe
// Streaming pipelined Gray<->binary converter, direction chosen per beat.
// The gray->bin prefix-XOR is split into STAGES chunks of CHUNK bits, MSB
// chunk first, one register slot per chunk. Optional build macro
// GRAY_CONV_CHECK_EN adds a gray-adjacency checker driving out_err;
// without it out_err is constant 0. DW must not exceed gray_pkg::GRAY_MAX_DW.
module gray_conv_pipe
  import gray_pkg::*;
#(
  parameter int DW     = 32,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_err
);

  localparam int CHUNK = (DW + STAGES - 1) / STAGES;

  // Index k is the input of slot k; index STAGES is the pipe output.
  logic [STAGES:0]         w_valid;
  logic [STAGES:0]         w_ready;
  logic [STAGES:0]         w_mode;
  logic [STAGES:0][DW-1:0] w_data;
  logic [STAGES:0]         w_carry;
  logic [STAGES:0]         w_err;
  logic                    w_unused_tail;

  assign w_valid[0]      = in_valid;
  assign w_mode[0]       = in_mode;
  assign w_data[0]       = in_data;
  assign w_carry[0]      = 1'b0;
  assign w_ready[STAGES] = out_ready;
  assign in_ready        = w_ready[0];
  assign out_valid       = w_valid[STAGES];
  assign out_data        = w_data[STAGES];
  assign out_err         = w_err[STAGES];
  // Mode and carry are only needed between slots.
  assign w_unused_tail   = w_mode[STAGES] ^ w_carry[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI     = DW - 1 - k * CHUNK;
    localparam int LO_RAW = HI - CHUNK + 1;
    localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

    gray_conv_stage #(
      .DW    (DW),
      .HI    (HI),
      .LO    (LO),
      .FIRST (k == 0)
    ) u_stage (
      .clk       (clk),
      .nreset    (nreset),
      .in_valid  (w_valid[k]),
      .in_ready  (w_ready[k]),
      .in_mode   (w_mode[k]),
      .in_data   (w_data[k]),
      .in_carry  (w_carry[k]),
      .in_err    (w_err[k]),
      .out_valid (w_valid[k+1]),
      .out_ready (w_ready[k+1]),
      .out_mode  (w_mode[k+1]),
      .out_data  (w_data[k+1]),
      .out_carry (w_carry[k+1]),
      .out_err   (w_err[k+1])
    );
  end

`ifdef GRAY_CONV_CHECK_EN
  logic [DW-1:0]          r_hist;
  logic                   r_hist_vld;
  logic                   w_accept;
  logic [GRAY_MAX_DW-1:0] w_diff_ext;
  logic                   w_flag;

  assign w_accept = in_valid && w_ready[0];

  // Flag a gray beat that moves more than one bit from the previous gray beat.
  always_comb begin
    w_diff_ext         = {GRAY_MAX_DW{1'b0}};
    w_diff_ext[DW-1:0] = in_data ^ r_hist;
    if (r_hist_vld && (in_mode == MODE_G2B)) begin
      w_flag = gray_popcnt_gt1(w_diff_ext);
    end else begin
      w_flag = 1'b0;
    end
  end

  // Remember the last accepted gray->bin operand; bin->gray beats leave it alone.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_hist     <= {DW{1'b0}};
      r_hist_vld <= 1'b0;
    end else if (w_accept && (in_mode == MODE_G2B)) begin
      r_hist     <= in_data;
      r_hist_vld <= 1'b1;
    end
  end

  assign w_err[0] = w_flag;
`else
  assign w_err[0] = 1'b0;
`endif

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Directed bench for gray_conv_pipe: DW=8/STAGES=2 scenarios plus an
// exhaustive DW=13 sweep over STAGES=1,4,13.
`timescale 1ns/1ps
module tb_gray_conv_pipe;
  import gray_pkg::*;

  localparam int SW_N = 16384;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // DW=8 / STAGES=2 instance
  logic       in_valid, in_ready, in_mode, out_valid, out_ready, out_err;
  logic [7:0] in_data, out_data;

  gray_conv_pipe #(.DW(8), .STAGES(2)) u_dut (
    .clk(clk), .nreset(nreset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  // DW=13 sweep instances sharing one stimulus
  logic        sw_valid, sw_mode;
  logic [12:0] sw_data;
  logic [2:0]  sw_in_ready, sw_out_valid, sw_out_err;
  logic [12:0] sw_out_data [3];

  gray_conv_pipe #(.DW(13), .STAGES(1)) u_sw1 (
    .clk(clk), .nreset(nreset),
    .in_valid(sw_valid), .in_ready(sw_in_ready[0]), .in_mode(sw_mode), .in_data(sw_data),
    .out_valid(sw_out_valid[0]), .out_ready(1'b1), .out_data(sw_out_data[0]), .out_err(sw_out_err[0])
  );
  gray_conv_pipe #(.DW(13), .STAGES(4)) u_sw4 (
    .clk(clk), .nreset(nreset),
    .in_valid(sw_valid), .in_ready(sw_in_ready[1]), .in_mode(sw_mode), .in_data(sw_data),
    .out_valid(sw_out_valid[1]), .out_ready(1'b1), .out_data(sw_out_data[1]), .out_err(sw_out_err[1])
  );
  gray_conv_pipe #(.DW(13), .STAGES(13)) u_sw13 (
    .clk(clk), .nreset(nreset),
    .in_valid(sw_valid), .in_ready(sw_in_ready[2]), .in_mode(sw_mode), .in_data(sw_data),
    .out_valid(sw_out_valid[2]), .out_ready(1'b1), .out_data(sw_out_data[2]), .out_err(sw_out_err[2])
  );

  // Handshake log of the DW=8 instance, sampled on the falling edge.
  logic [7:0] dq_data [$];
  logic       dq_err  [$];
  int         dq_cyc  [$];
  int         aq_cyc  [$];

  always @(negedge clk) begin
    if (nreset) begin
      if (in_valid && in_ready) aq_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        dq_data.push_back(out_data);
        dq_err.push_back(out_err);
        dq_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [12:0] ref_g2b13(input logic [12:0] g);
    logic [12:0] b;
    for (int i = 0; i < 13; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [12:0] ref_b2g13(input logic [12:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic clear_log();
    dq_data.delete(); dq_err.delete(); dq_cyc.delete(); aq_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic m, input logic [7:0] d);
    bit got;
    got = 1'b0;
    in_valid = 1'b1; in_mode = m; in_data = d;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: beat %h never accepted, in_ready 0 vs required 1", d);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; in_mode = MODE_G2B; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    nreset = 1'b1;
    clear_log();
    idle(6);
    n_vec++; if (dq_data.size() != 0) begin n_err++; $display("FAIL reset_no_beat: got %0d beats want 0", dq_data.size()); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_g2b();
    logic [7:0] exp_d [3];
    exp_d = '{8'h80, 8'hAA, 8'h01};
    clear_log();
    out_ready = 1'b1;
    send(MODE_G2B, 8'hC0);
    send(MODE_G2B, 8'hFF);
    send(MODE_G2B, 8'h01);
    idle(6);
    n_vec++;
    if (dq_data.size() != 3 || aq_cyc.size() != 3) begin
      n_err++; $display("FAIL g2b_count: got %0d/%0d beats want 3/3", aq_cyc.size(), dq_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (dq_data[i] !== exp_d[i]) begin n_err++; $display("FAIL g2b_data[%0d]: got %h want %h", i, dq_data[i], exp_d[i]); end
        n_vec++; if (dq_cyc[i] - aq_cyc[i] != 2) begin n_err++; $display("FAIL g2b_latency[%0d]: got %0d want 2", i, dq_cyc[i] - aq_cyc[i]); end
        if (i > 0) begin
          n_vec++; if (dq_cyc[i] - dq_cyc[i-1] != 1) begin n_err++; $display("FAIL g2b_gap[%0d]: got %0d want 1", i, dq_cyc[i] - dq_cyc[i-1]); end
        end
      end
    end
  endtask

  task automatic test_mixed();
    clear_log();
    out_ready = 1'b1;
    send(MODE_B2G, 8'h05);
    send(MODE_G2B, 8'h07);
    idle(6);
    n_vec++;
    if (dq_data.size() != 2) begin
      n_err++; $display("FAIL mixed_count: got %0d want 2", dq_data.size());
    end else begin
      n_vec++; if (dq_data[0] !== 8'h07) begin n_err++; $display("FAIL mixed_b2g: got %h want 07", dq_data[0]); end
      n_vec++; if (dq_data[1] !== 8'h05) begin n_err++; $display("FAIL mixed_g2b: got %h want 05", dq_data[1]); end
      n_vec++; if (dq_cyc[1] - dq_cyc[0] != 1) begin n_err++; $display("FAIL mixed_gap: got %0d want 1", dq_cyc[1] - dq_cyc[0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bp_in  [4];
    logic [7:0] bp_exp [4];
    int         idx;
    logic       acc;
    bp_in  = '{8'h10, 8'h20, 8'h30, 8'h40};
    bp_exp = '{8'h1F, 8'h3F, 8'h20, 8'h7F};
    clear_log();
    idx = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = MODE_G2B; in_data = bp_in[0];
    for (int j = 0; j < 40 && idx < 4; j++) begin
      if (j == 5) out_ready = 1'b1;
      @(negedge clk);
      if (j < 5) begin
        n_vec++;
        if (in_ready !== (j < 2)) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want %b", j, in_ready, (j < 2)); end
      end
      if (j >= 2 && j < 5) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h1F) begin
          n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=1f", j, out_valid, out_data);
        end
      end
      acc = in_ready;
      @(posedge clk); #2;
      if (acc) begin
        idx++;
        if (idx < 4) in_data = bp_in[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    for (int t = 0; t < 20 && dq_data.size() < 4; t++) idle(1);
    idle(3);
    n_vec++;
    if (dq_data.size() != 4) begin
      n_err++; $display("FAIL bp_count: got %0d beats want 4", dq_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++; if (dq_data[i] !== bp_exp[i]) begin n_err++; $display("FAIL bp_order[%0d]: got %h want %h", i, dq_data[i], bp_exp[i]); end
      end
    end
  endtask

  task automatic test_checker();
    logic [7:0] exp_d [3];
    logic       exp_e [3];
    exp_d = '{8'h05, 8'h06, 8'h00};
`ifdef GRAY_CONV_CHECK_EN
    exp_e = '{1'b0, 1'b0, 1'b1};
`else
    exp_e = '{1'b0, 1'b0, 1'b0};
`endif
    nreset = 1'b0;
    idle(1);
    nreset = 1'b1;
    clear_log();
    out_ready = 1'b1;
    send(MODE_G2B, 8'h07);
    send(MODE_G2B, 8'h05);
    send(MODE_G2B, 8'h00);
    idle(6);
    n_vec++;
    if (dq_data.size() != 3) begin
      n_err++; $display("FAIL chk_count: got %0d want 3", dq_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (dq_data[i] !== exp_d[i]) begin n_err++; $display("FAIL chk_data[%0d]: got %h want %h", i, dq_data[i], exp_d[i]); end
        n_vec++; if (dq_err[i] !== exp_e[i]) begin n_err++; $display("FAIL chk_err[%0d]: got %b want %b", i, dq_err[i], exp_e[i]); end
      end
    end
  endtask

  task automatic test_sweep();
    int          stg [3];
    int          n;
    int          m;
    logic [12:0] expd;
    stg = '{1, 4, 13};
    sw_valid = 1'b1; sw_mode = MODE_G2B; sw_data = 13'd0;
    for (int c = 0; c < SW_N + 16; c++) begin
      @(negedge clk);
      if (c < SW_N) begin
        n_vec++;
        if (sw_in_ready !== 3'b111) begin n_err++; $display("FAIL sweep_in_ready[%0d]: got %b want 111", c, sw_in_ready); end
      end
      for (int k = 0; k < 3; k++) begin
        n = c - stg[k];
        if (n >= 0 && n < SW_N) begin
          expd = (n < 8192) ? ref_g2b13(n[12:0]) : ref_b2g13(n[12:0]);
          n_vec++;
          if (sw_out_valid[k] !== 1'b1 || sw_out_data[k] !== expd || (n >= 8192 && sw_out_err[k] !== 1'b0)) begin
            n_err++;
            $display("FAIL sweep_s%0d[%0d]: got v=%b d=%h e=%b want v=1 d=%h", stg[k], n, sw_out_valid[k], sw_out_data[k], sw_out_err[k], expd);
          end
        end else begin
          n_vec++;
          if (sw_out_valid[k] !== 1'b0) begin n_err++; $display("FAIL sweep_s%0d_idle[%0d]: got v=%b want 0", stg[k], c, sw_out_valid[k]); end
        end
      end
      @(posedge clk); #2;
      m = c + 1;
      if (m < SW_N) begin
        sw_data = m[12:0];
        sw_mode = (m >= 8192) ? MODE_B2G : MODE_G2B;
      end else begin
        sw_valid = 1'b0;
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; in_mode = MODE_G2B; in_data = 8'h00; out_ready = 1'b1;
    sw_valid = 1'b0; sw_mode = MODE_G2B; sw_data = 13'd0;
    #3;
    test_reset();
    test_g2b();
    test_mixed();
    test_backpressure();
    test_checker();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
